// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receive path.
//   rx_state_e : receiver FSM states (IDLE, START, DATA, PARITY, STOP)
//   MIN_DIV    : smallest usable clocks-per-bit value
//   fifo_aw()  : address width for a power-of-2 FIFO depth
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int unsigned MIN_DIV = 4;

  function automatic int unsigned fifo_aw(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst       : clock, synchronous active-high reset
//   push/push_data : write request; accepted when not full, or full with a pop
//   pop            : read request; ignored while empty
//   pop_data       : head entry (0 while empty)
//   full/empty     : occupancy flags
//   count          : occupied entries, 0..DEPTH
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [fifo_aw(DEPTH):0]    count
);

  localparam int unsigned AW = fifo_aw(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push_ok  = push & (~full | pop_ok);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + (AW+1)'(1);
      else if (pop_ok && !push_ok) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with FWFT receive FIFO and sticky error flags.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   clk_div            : clocks per bit (values below MIN_DIV act as MIN_DIV)
//   rx_i               : asynchronous serial input, idle high
//   rx_data/rx_valid   : FIFO head and non-empty flag; popped by rx_ready
//   fifo_count         : FIFO occupancy
//   frame_err, overrun, parity_err : sticky, cleared by err_clr
//   irq                : any of rx_valid or the error flags
// Build option: define UART_RX_PARITY_EN for an even-parity bit between data
// and stop; otherwise 8N1 and parity_err is held at 0.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [DIV_W-1:0]              clk_div,
  input  logic                          rx_i,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [fifo_aw(FIFO_DEPTH):0]  fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err,
  input  logic                          err_clr,
  output logic                          irq
);

  localparam int unsigned BCW = $clog2(DATA_BITS + 1);

  logic                 rx_s1;
  logic                 rx_s2;
  logic                 rx_prev;
  rx_state_e            state;
  logic [DIV_W-1:0]     cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic [DIV_W-1:0]     div_eff;
  logic                 tick;
  logic                 push;
  logic                 stop_bad;
  logic                 full;
  logic                 empty;

  assign div_eff  = (clk_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : clk_div;
  assign tick     = (cnt == DIV_W'(1));
  assign push     = (state == STOP) && tick && rx_s2 && !par_bad;
  assign stop_bad = (state == STOP) && tick && !rx_s2;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // The counter is loaded with N and the line is sampled on the cycle it
  // reads 1, i.e. N cycles after the load.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_prev && !rx_s2) begin
            state <= START;
            cnt   <= div_eff >> 1;
          end
        end
        START: begin
          if (tick) begin
            if (rx_s2) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              cnt     <= div_eff;
              bit_cnt <= '0;
              par_bad <= 1'b0;
            end
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= {rx_s2, shreg[DATA_BITS-1:1]};
            cnt   <= div_eff;
            if (bit_cnt == BCW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        PARITY: begin
          if (tick) begin
            par_bad <= rx_s2 ^ (^shreg);
            state   <= STOP;
            cnt     <= div_eff;
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        STOP: begin
          if (tick) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as err_clr wins.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (stop_bad)                      frame_err <= 1'b1;
      else if (err_clr)                  frame_err <= 1'b0;
      if (push && full && !rx_ready)     overrun   <= 1'b1;
      else if (err_clr)                  overrun   <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      parity_err <= 1'b0;
    end else if ((state == STOP) && tick && par_bad) begin
      parity_err <= 1'b1;
    end else if (err_clr) begin
      parity_err <= 1'b0;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (push),
    .push_data (shreg),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign rx_valid = ~empty;
  assign irq      = rx_valid | frame_err | overrun | parity_err;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  import uart_rx_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] clk_div;
  logic        rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [2:0]  fifo_count;
  logic        frame_err;
  logic        overrun;
  logic        parity_err;
  logic        err_clr;
  logic        irq;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [7:0]  exp_q[$];

  uart_rx #(
    .DATA_BITS  (8),
    .FIFO_DEPTH (4),
    .DIV_W      (16)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .clk_div    (clk_div),
    .rx_i       (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .err_clr    (err_clr),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a pop happens on the next posedge whenever valid and
  // ready are both high, so compare the head now.
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", {24'h0, rx_data}, 32'hFFFF_FFFF);
      end else begin
        check("pop_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic drive_bit(input logic v, input int unsigned cycles);
    rx = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int unsigned per,
                            input logic par_en, input logic par);
    drive_bit(1'b0, per);
    for (int i = 0; i < 8; i++) drive_bit(d[i], per);
    if (par_en) drive_bit(par, per);
    drive_bit(stop_b, per);
    drive_bit(1'b1, per * 2);
  endtask

  task automatic wait_valid(input string name, input int unsigned max_cycles);
    int unsigned n;
    n = 0;
    while (!rx_valid && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rx_valid) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic drain(input string name);
    int unsigned n;
    rx_ready = 1'b1;
    n = 0;
    while (rx_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    rx_ready = 1'b0;
    check({name, "_drained"}, {31'h0, rx_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clk_div = 16'd8; rx = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'h0, rx_valid}, 32'd0);
    check("rst_count", {29'h0, fifo_count}, 32'd0);
    check("rst_irq",   {31'h0, irq}, 32'd0);
    check("rst_data",  {24'h0, rx_data}, 32'd0);
    rst = 1'b0;
    drive_bit(1'b1, 8);

    // 1: single good frame
    send_frame(8'h3D, 1'b1, 8, 1'b0, 1'b0);
    wait_valid("t1", 30);
    check("t1_data",  {24'h0, rx_data}, 32'h3D);
    check("t1_count", {29'h0, fifo_count}, 32'd1);
    check("t1_ferr",  {31'h0, frame_err}, 32'd0);
    check("t1_irq",   {31'h0, irq}, 32'd1);
    exp_q.push_back(8'h3D);
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    check("t1_valid_after_pop", {31'h0, rx_valid}, 32'd0);

    // 2: start-bit glitch
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 30);
    check("t2_count", {29'h0, fifo_count}, 32'd0);
    check("t2_irq",   {31'h0, irq}, 32'd0);

    // 3: bad stop bit
    send_frame(8'h0F, 1'b0, 8, 1'b0, 1'b0);
    check("t3_ferr",  {31'h0, frame_err}, 32'd1);
    check("t3_count", {29'h0, fifo_count}, 32'd0);
    check("t3_irq",   {31'h0, irq}, 32'd1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("t3_ferr_clr", {31'h0, frame_err}, 32'd0);
    check("t3_irq_clr",  {31'h0, irq}, 32'd0);

    // 4: overflow
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 8, 1'b0, 1'b0);
      if (i <= 4) exp_q.push_back(8'(i));
    end
    check("t4_count",   {29'h0, fifo_count}, 32'd4);
    check("t4_overrun", {31'h0, overrun}, 32'd1);
    check("t4_head",    {24'h0, rx_data}, 32'h01);
    drain("t4");
    check("t4_count_empty", {29'h0, fifo_count}, 32'd0);
    check("t4_overrun_held", {31'h0, overrun}, 32'd1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("t4_overrun_clr", {31'h0, overrun}, 32'd0);

    // 5: reset mid-frame
    send_frame(8'h11, 1'b1, 8, 1'b0, 1'b0);
    check("t5_pre_count", {29'h0, fifo_count}, 32'd1);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 24);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_count", {29'h0, fifo_count}, 32'd0);
    check("t5_rst_valid", {31'h0, rx_valid}, 32'd0);
    check("t5_rst_irq",   {31'h0, irq}, 32'd0);
    rst = 1'b0;
    drive_bit(1'b1, 80);
    check("t5_no_ghost", {29'h0, fifo_count}, 32'd0);
    send_frame(8'hA5, 1'b1, 8, 1'b0, 1'b0);
    exp_q.push_back(8'hA5);
    check("t5_count", {29'h0, fifo_count}, 32'd1);
    drain("t5");

    // clk_div below the minimum behaves as MIN_DIV
    clk_div = 16'd2;
    send_frame(8'hC6, 1'b1, MIN_DIV, 1'b0, 1'b0);
    check("t7_count", {29'h0, fifo_count}, 32'd1);
    check("t7_ferr",  {31'h0, frame_err}, 32'd0);
    exp_q.push_back(8'hC6);
    drain("t7");
    clk_div = 16'd8;

`ifdef UART_RX_PARITY_EN
    // 6: even parity
    send_frame(8'h0F, 1'b1, 8, 1'b1, 1'b1);
    check("t6_perr",  {31'h0, parity_err}, 32'd1);
    check("t6_count", {29'h0, fifo_count}, 32'd0);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("t6_perr_clr", {31'h0, parity_err}, 32'd0);
    send_frame(8'h0F, 1'b1, 8, 1'b1, 1'b0);
    check("t6_good_count", {29'h0, fifo_count}, 32'd1);
    check("t6_good_perr",  {31'h0, parity_err}, 32'd0);
    exp_q.push_back(8'h0F);
    drain("t6");
`else
    check("perr_tied", {31'h0, parity_err}, 32'd0);
`endif

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
